spi_regfile_peripheral: RTL and testbench

Parametrised SPI (mode 0) peripheral that gives an external host write and read-back access to a bank of NUM_REGS configuration registers, each DATA_W bits wide. It oversamples SCLK/COPI/nCS in the system clock domain and exports the register bank as a flat bus to the PWM/output-enable logic. Compared with the fixed 5x8 write-only generation, it adds a CIPO read path, a write strobe, and a frame-error flag.

---
 rtl/spi_regfile_peripheral.sv | 224 ++++++++++++++++++++++
 tb/tb_spi_regfile_peripheral.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_regfile_peripheral.sv
// SPI mode-0 peripheral exposing a bank of NUM_REGS x DATA_W registers.
// Frame: R/W bit, ADDR_W address bits, DATA_W data bits, all MSB first and
// sampled on SCLK rising edges. Writes commit when nCS rises. Reads shift
// out on SCLK falling edges.
// Ports:
//   clk, rst_n        system clock, async active-low reset
//   SCLK, COPI, nCS   SPI pins, asynchronous to clk
//   CIPO, cipo_oe     read data and its pad output enable
//   regs_flat         register bank, reg i at [i*DATA_W +: DATA_W]
//   wr_strobe         one-clk pulse per committed write
//   wr_addr           address of the last committed write
//   frame_err         one-clk pulse per rejected frame
module spi_regfile_peripheral #(
    parameter int unsigned NUM_REGS = 5,
    parameter int unsigned DATA_W   = 8,
    parameter int unsigned ADDR_W   = 7
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         SCLK,
    input  logic                         COPI,
    input  logic                         nCS,
    output logic                         CIPO,
    output logic                         cipo_oe,
    output logic [NUM_REGS*DATA_W-1:0]   regs_flat,
    output logic                         wr_strobe,
    output logic [ADDR_W-1:0]            wr_addr,
    output logic                         frame_err
);

    localparam int unsigned FRAME_LEN = 1 + ADDR_W + DATA_W;
    localparam int unsigned CNT_W     = $clog2(FRAME_LEN + 1);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_CMD  = 3'd1;
    localparam logic [2:0] S_ADDR = 3'd2;
    localparam logic [2:0] S_DATA = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;

    logic [2:0]           r_sclk_q;
    logic [2:0]           r_ncs_q;
    logic [1:0]           r_copi_q;
    logic [2:0]           r_state;
    logic [2:0]           w_state_nxt;
    logic [CNT_W-1:0]     r_cnt;
    logic [FRAME_LEN-1:0] r_shift;
    logic [DATA_W-1:0]    r_tx;
    logic                 r_cipo;
    logic                 r_oe;
    logic                 r_wr_strobe;
    logic [ADDR_W-1:0]    r_wr_addr;
    logic                 r_frame_err;
    logic [DATA_W-1:0]    r_regs [NUM_REGS];

    logic                 w_sclk_rise;
    logic                 w_sclk_fall;
    logic                 w_ncs_rise;
    logic                 w_ncs_fall;
    logic                 w_shift_en;
    logic                 w_tx_shift;
    logic                 w_load;
    logic                 w_commit;
    logic                 w_err;
    logic                 w_rw;
    logic [ADDR_W-1:0]    w_addr;
    logic [DATA_W-1:0]    w_data;
    logic                 w_full;
    logic                 w_addr_ok;
    logic [ADDR_W-1:0]    w_rd_addr;
    logic                 w_rd_rw;
    logic                 w_rd_ok;
    logic [DATA_W-1:0]    w_rd_word;

    // Two-flop synchronisers plus a third copy for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sclk_q <= 3'b000;
            r_ncs_q  <= 3'b111;
            r_copi_q <= 2'b00;
        end else begin
            r_sclk_q <= {r_sclk_q[1:0], SCLK};
            r_ncs_q  <= {r_ncs_q[1:0], nCS};
            r_copi_q <= {r_copi_q[0], COPI};
        end
    end

    assign w_sclk_rise = r_sclk_q[1] & ~r_sclk_q[2];
    assign w_sclk_fall = ~r_sclk_q[1] & r_sclk_q[2];
    assign w_ncs_rise  = r_ncs_q[1] & ~r_ncs_q[2];
    assign w_ncs_fall  = ~r_ncs_q[1] & r_ncs_q[2];

    // SCLK edges coinciding with an nCS edge are dropped; DONE ignores SCLK.
    assign w_shift_en = w_sclk_rise && !w_ncs_rise && !w_ncs_fall &&
                        (r_state == S_CMD || r_state == S_ADDR || r_state == S_DATA);
    assign w_tx_shift = w_sclk_fall && !w_ncs_rise && !w_ncs_fall && (r_state == S_DATA);

    // Completed-frame fields, valid only when the full frame was received.
    assign w_rw      = r_shift[FRAME_LEN-1];
    assign w_addr    = r_shift[FRAME_LEN-2 -: ADDR_W];
    assign w_data    = r_shift[DATA_W-1:0];
    assign w_full    = (r_cnt == CNT_W'(FRAME_LEN));
    assign w_addr_ok = (32'(w_addr) < NUM_REGS);

    // Address as it stands once the incoming bit (the last address bit) lands.
    assign w_rd_addr = ADDR_W'({r_shift, r_copi_q[1]});
    assign w_rd_rw   = r_shift[ADDR_W-1];
    assign w_rd_ok   = (32'(w_rd_addr) < NUM_REGS);

    always_comb begin
        w_rd_word = '0;
        for (int i = 0; i < int'(NUM_REGS); i++) begin
            if (w_rd_ok && w_rd_addr == ADDR_W'(i)) begin
                w_rd_word = r_regs[i];
            end
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state and frame-level decisions.
    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_commit    = 1'b0;
        w_err       = 1'b0;
        if (w_ncs_fall) begin
            w_state_nxt = S_CMD;
        end else if (w_ncs_rise) begin
            w_state_nxt = S_IDLE;
            w_commit    = w_full && w_rw && w_addr_ok;
            w_err       = (r_cnt != '0) && !(w_full && w_addr_ok);
        end else if (w_shift_en) begin
            case (r_state)
                S_CMD:  w_state_nxt = S_ADDR;
                S_ADDR: begin
                    if (r_cnt == CNT_W'(ADDR_W)) begin
                        w_state_nxt = S_DATA;
                        w_load      = 1'b1;
                    end
                end
                S_DATA: begin
                    if (r_cnt == CNT_W'(FRAME_LEN - 1)) begin
                        w_state_nxt = S_DONE;
                    end
                end
                default: ;
            endcase
        end
    end

    // Bit counter, input shifter, read shifter and status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt       <= '0;
            r_shift     <= '0;
            r_tx        <= '0;
            r_cipo      <= 1'b0;
            r_oe        <= 1'b0;
            r_wr_strobe <= 1'b0;
            r_wr_addr   <= '0;
            r_frame_err <= 1'b0;
        end else begin
            r_wr_strobe <= w_commit;
            r_frame_err <= w_err;
            r_oe        <= ~r_ncs_q[1];
            if (w_commit) begin
                r_wr_addr <= w_addr;
            end
            if (w_ncs_fall || w_ncs_rise) begin
                r_cnt   <= '0;
                r_shift <= '0;
            end else if (w_shift_en) begin
                r_cnt   <= r_cnt + CNT_W'(1);
                r_shift <= {r_shift[FRAME_LEN-2:0], r_copi_q[1]};
            end
            // Only reads load real data; writes shift out zeros.
            if (w_ncs_fall || w_ncs_rise) begin
                r_tx <= '0;
            end else if (w_load) begin
                r_tx <= w_rd_rw ? '0 : w_rd_word;
            end else if (w_tx_shift) begin
                r_tx <= r_tx << 1;
            end
            if (w_state_nxt != S_DATA || r_ncs_q[1]) begin
                r_cipo <= 1'b0;
            end else if (w_tx_shift) begin
                r_cipo <= r_tx[DATA_W-1];
            end
        end
    end

    // Register bank: only the addressed register takes a committed write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(NUM_REGS); i++) begin
                r_regs[i] <= '0;
            end
        end else begin
            for (int i = 0; i < int'(NUM_REGS); i++) begin
                if (w_commit && w_addr == ADDR_W'(i)) begin
                    r_regs[i] <= w_data;
                end
            end
        end
    end

    for (genvar g = 0; g < int'(NUM_REGS); g++) begin : g_flat
        assign regs_flat[g*DATA_W +: DATA_W] = r_regs[g];
    end

    assign CIPO      = r_cipo;
    assign cipo_oe   = r_oe;
    assign wr_strobe = r_wr_strobe;
    assign wr_addr   = r_wr_addr;
    assign frame_err = r_frame_err;

endmodule

// File: tb/tb_spi_regfile_peripheral.sv
// Bench for spi_regfile_peripheral: a default 5x8 instance and a 16x16
// instance sharing SCLK/COPI with separate chip selects.
module tb_spi_regfile_peripheral;

    localparam int HALF = 6;

    logic clk = 1'b0;
    logic rst_n;
    logic SCLK, COPI, nCS0, nCS1;

    logic         CIPO0, oe0, str0, err0;
    logic [39:0]  regs0;
    logic [6:0]   waddr0;
    logic         CIPO1, oe1, str1, err1;
    logic [255:0] regs1;
    logic [3:0]   waddr1;

    int tests = 0;
    int fails = 0;
    int n_str0 = 0, n_err0 = 0, n_str1 = 0, n_err1 = 0, n_both = 0;

    logic [7:0] m_regs [5];
    logic [6:0] m_wr_addr;

    always #5 clk = ~clk;

    spi_regfile_peripheral u_dut0 (
        .clk(clk), .rst_n(rst_n), .SCLK(SCLK), .COPI(COPI), .nCS(nCS0),
        .CIPO(CIPO0), .cipo_oe(oe0), .regs_flat(regs0),
        .wr_strobe(str0), .wr_addr(waddr0), .frame_err(err0)
    );

    spi_regfile_peripheral #(.NUM_REGS(16), .DATA_W(16), .ADDR_W(4)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .SCLK(SCLK), .COPI(COPI), .nCS(nCS1),
        .CIPO(CIPO1), .cipo_oe(oe1), .regs_flat(regs1),
        .wr_strobe(str1), .wr_addr(waddr1), .frame_err(err1)
    );

    // Count asserted cycles so stretched pulses are caught too.
    always @(posedge clk) begin
        if (str0) n_str0++;
        if (err0) n_err0++;
        if (str1) n_str1++;
        if (err1) n_err1++;
        if ((str0 && err0) || (str1 && err1)) n_both++;
    end

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [39:0] model_flat();
        logic [39:0] f;
        for (int i = 0; i < 5; i++) f[i*8 +: 8] = m_regs[i];
        return f;
    endfunction

    // Shift nbits of val out MSB first; sample CIPO and cipo_oe at each rising edge.
    task automatic send_bits(input logic [63:0] val, input int nbits, input bit sel,
                             output logic [63:0] rx, output int oe_bad);
        rx = '0;
        oe_bad = 0;
        for (int i = 0; i < nbits; i++) begin
            COPI = val[nbits-1-i];
            repeat (HALF) @(negedge clk);
            SCLK = 1'b1;
            rx = {rx[62:0], (sel ? CIPO1 : CIPO0)};
            if (!(sel ? oe1 : oe0)) oe_bad++;
            repeat (HALF) @(negedge clk);
            SCLK = 1'b0;
        end
    endtask

    task automatic spi_frame(input logic [63:0] val, input int nbits, input bit sel,
                             output logic [63:0] rx, output int oe_bad);
        if (sel) nCS1 = 1'b0; else nCS0 = 1'b0;
        repeat (HALF) @(negedge clk);
        send_bits(val, nbits, sel, rx, oe_bad);
        repeat (HALF) @(negedge clk);
        nCS0 = 1'b1;
        nCS1 = 1'b1;
        COPI = 1'b0;
    endtask

    // One frame to the 5x8 instance, checked against the reference model.
    task automatic run_frame0(input logic [63:0] val, input int nbits,
                              output int ds, output int de, output logic [7:0] rd);
        int s0, e0, oe_bad, addr;
        logic [63:0] rx;
        logic [15:0] top;
        logic [7:0] data, m_rd;
        bit full, rw, m_commit, m_err;
        s0 = n_str0;
        e0 = n_err0;
        full = (nbits >= 16);
        top = full ? 16'(val >> (nbits - 16)) : 16'h0;
        rw = top[15];
        addr = int'(top[14:8]);
        data = top[7:0];
        m_rd = (addr < 5) ? m_regs[addr] : 8'h00;
        m_commit = full && rw && (addr < 5);
        m_err = (nbits > 0) && !(full && addr < 5);
        spi_frame(val, nbits, 1'b0, rx, oe_bad);
        repeat (10) @(negedge clk);
        if (m_commit) begin
            m_regs[addr] = data;
            m_wr_addr = 7'(addr);
        end
        ds = n_str0 - s0;
        de = n_err0 - e0;
        rd = full ? 8'(rx >> (nbits - 16)) : 8'h00;
        check("wr_strobe_count", 256'(ds), 256'(m_commit));
        check("frame_err_count", 256'(de), 256'(m_err));
        check("regs_flat", 256'(regs0), 256'(model_flat()));
        check("wr_addr", 256'(waddr0), 256'(m_wr_addr));
        if (full && !rw) check("read_data", 256'(rd), 256'(m_rd));
        if (nbits > 0) check("oe_during_frame", 256'(oe_bad), 256'(0));
        check("idle_oe_cipo", 256'({oe0, CIPO0}), 256'(0));
    endtask

    typedef struct {
        logic [63:0] val;
        int          nbits;
        logic        exp_str;
        logic        exp_err;
        logic [7:0]  exp_rd;
        logic        chk_rd;
    } vec_t;

    vec_t tbl [12];

    initial begin
        int ds, de, oe_bad, nb, s0, e0;
        logic [7:0] rd;
        logic [63:0] rx, v;
        logic [15:0] f16;

        tbl[0]  = '{64'h80A5,  16, 1'b1, 1'b0, 8'h00, 1'b0};
        tbl[1]  = '{64'h8480,  16, 1'b1, 1'b0, 8'h00, 1'b0};
        tbl[2]  = '{64'h823C,  16, 1'b1, 1'b0, 8'h00, 1'b0};
        tbl[3]  = '{64'h0200,  16, 1'b0, 1'b0, 8'h3C, 1'b1};
        tbl[4]  = '{64'h85FF,  16, 1'b0, 1'b1, 8'h00, 1'b0};
        tbl[5]  = '{64'h0900,  16, 1'b0, 1'b1, 8'h00, 1'b1};
        tbl[6]  = '{64'h0205,  10, 1'b0, 1'b1, 8'h00, 1'b0};
        tbl[7]  = '{64'h815AF, 20, 1'b1, 1'b0, 8'h00, 1'b0};
        tbl[8]  = '{64'h0100,  16, 1'b0, 1'b0, 8'h5A, 1'b1};
        tbl[9]  = '{64'h0000,  16, 1'b0, 1'b0, 8'hA5, 1'b1};
        tbl[10] = '{64'h0400,  16, 1'b0, 1'b0, 8'h80, 1'b1};
        tbl[11] = '{64'h0000,   0, 1'b0, 1'b0, 8'h00, 1'b0};

        for (int i = 0; i < 5; i++) m_regs[i] = 8'h00;
        m_wr_addr = 7'h00;

        rst_n = 1'b0;
        SCLK = 1'b0;
        COPI = 1'b0;
        nCS0 = 1'b1;
        nCS1 = 1'b1;
        repeat (4) @(negedge clk);
        check("reset_outputs0", 256'({regs0, waddr0, CIPO0, oe0, str0, err0}), 256'(0));
        check("reset_outputs1", regs1, 256'(0));
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        // Directed vectors with hand-derived expectations.
        for (int k = 0; k < 12; k++) begin
            run_frame0(tbl[k].val, tbl[k].nbits, ds, de, rd);
            check($sformatf("tbl%0d_strobe", k), 256'(ds), 256'(tbl[k].exp_str));
            check($sformatf("tbl%0d_err", k), 256'(de), 256'(tbl[k].exp_err));
            if (tbl[k].chk_rd) check($sformatf("tbl%0d_rd", k), 256'(rd), 256'(tbl[k].exp_rd));
        end
        check("tbl_reg0", 256'(regs0[7:0]), 256'(8'hA5));
        check("tbl_reg4", 256'(regs0[39:32]), 256'(8'h80));

        // nCS fall-rise-fall: the aborted frame errors, the next one commits.
        e0 = n_err0;
        s0 = n_str0;
        nCS0 = 1'b0;
        repeat (HALF) @(negedge clk);
        send_bits(64'h10, 5, 1'b0, rx, oe_bad);
        repeat (HALF) @(negedge clk);
        nCS0 = 1'b1;
        repeat (5) @(negedge clk);
        check("abort_err", 256'(n_err0 - e0), 256'(1));
        check("abort_no_strobe", 256'(n_str0 - s0), 256'(0));
        run_frame0(64'h81C3, 16, ds, de, rd);
        check("after_abort_reg1", 256'(regs0[15:8]), 256'(8'hC3));

        // Reset in the middle of a write frame.
        nCS0 = 1'b0;
        repeat (HALF) @(negedge clk);
        send_bits(64'h8377 >> 7, 9, 1'b0, rx, oe_bad);
        rst_n = 1'b0;
        #1;
        check("midreset_outputs", 256'({regs0, waddr0, CIPO0, oe0, str0, err0}), 256'(0));
        for (int i = 0; i < 5; i++) m_regs[i] = 8'h00;
        m_wr_addr = 7'h00;
        repeat (3) @(negedge clk);
        nCS0 = 1'b1;
        SCLK = 1'b0;
        COPI = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        run_frame0(64'h8377, 16, ds, de, rd);
        check("postreset_strobe", 256'(ds), 256'(1));
        check("postreset_reg3", 256'(regs0[31:24]), 256'(8'h77));

        // Randomised frames against the model.
        for (int n = 0; n < 40; n++) begin
            f16 = {1'($urandom_range(0, 1)), 7'($urandom_range(0, 7)), 8'($urandom)};
            nb = ($urandom_range(0, 9) < 6) ? 16 : int'($urandom_range(1, 20));
            if (nb >= 16) begin
                v = ({48'h0, f16} << (nb - 16)) |
                    (64'($urandom_range(0, 15)) & ((64'd1 << (nb - 16)) - 64'd1));
            end else begin
                v = {48'h0, f16} >> (16 - nb);
            end
            run_frame0(v, nb, ds, de, rd);
        end

        // Wide instance: 21-bit frames, write then read back address 15.
        s0 = n_str1;
        e0 = n_err1;
        spi_frame(64'h1FBEEF, 21, 1'b1, rx, oe_bad);
        repeat (10) @(negedge clk);
        check("w16_reg15", 256'(regs1[255:240]), 256'(16'hBEEF));
        check("w16_others", 256'(regs1[239:0]), 256'(0));
        check("w16_strobe", 256'(n_str1 - s0), 256'(1));
        check("w16_wr_addr", 256'(waddr1), 256'(4'hF));
        spi_frame(64'h0F0000, 21, 1'b1, rx, oe_bad);
        repeat (10) @(negedge clk);
        check("r16_data", 256'(rx[15:0]), 256'(16'hBEEF));
        check("r16_oe", 256'(oe_bad), 256'(0));
        check("w16_no_err", 256'(n_err1 - e0), 256'(0));
        check("r16_no_strobe", 256'(n_str1 - s0), 256'(1));

        check("strobe_err_overlap", 256'(n_both), 256'(0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
